// File: rtl/fetch_sequencer.sv
// fetch_sequencer: two-phase instruction fetch / program-counter stage.
// FETCH presents PC on IMEM_ADDR and latches the ROM word into IR at the end
// of the cycle. EXEC exposes OPCode/A to the decoder and applies its strobes
// to compute the next PC. The address is held steady for the whole FETCH
// cycle and comes straight from the PC register, so the decoder strobes never
// reach the ROM address combinationally. A small return-address stack
// serves Call/ret.
module fetch_sequencer #(
  parameter int              AW        = 16,
  parameter int              IW        = 16,
  parameter int              DEPTH     = 8,
  parameter logic [AW-1:0]   RESET_VEC = '0
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic                   STALL,
  output logic [AW-1:0]          IMEM_ADDR,
  input  logic [IW-1:0]          IMEM_DATA,
  output logic [IW-1:0]          IR,
  output logic [4:0]             OPCode,
  output logic [1:0]             A,
  output logic                   EXEC,
  input  logic                   PCpp,
  input  logic                   JMP,
  input  logic                   ret,
  input  logic                   Call,
  input  logic [AW-1:0]          JADDR,
  output logic [$clog2(DEPTH):0] SP,
  output logic                   OVF,
  output logic                   UNF
);
  localparam int             SPW     = $clog2(DEPTH) + 1;
  localparam int             IXW     = SPW - 1;
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  typedef enum logic {S_FETCH = 1'b0, S_EXEC = 1'b1} state_t;

  state_t         r_state, w_state_nxt;
  logic [AW-1:0]  r_pc, w_pc_nxt, w_pc_inc;
  logic [IW-1:0]  r_ir;
  logic [SPW-1:0] r_sp, w_sp_nxt, w_sp_dec;
  logic           r_ovf, r_unf, w_ovf_nxt, w_unf_nxt;
  logic [AW-1:0]  r_stack [DEPTH];
  logic           w_exec, w_step, w_load_ir, w_push;

  // State register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) r_state <= S_FETCH;
    else       r_state <= w_state_nxt;
  end

  // Next state: strict FETCH/EXEC alternation, frozen while stalled.
  always_comb begin
    w_state_nxt = r_state;
    if (!STALL) begin
      if (r_state == S_FETCH) w_state_nxt = S_EXEC;
      else                    w_state_nxt = S_FETCH;
    end
  end

  // FSM outputs: EXEC flag, and qualified update enables for IR and PC.
  always_comb begin
    w_exec    = (r_state == S_EXEC);
    w_step    = w_exec && !STALL;
    w_load_ir = !w_exec && !STALL;
  end

  assign w_pc_inc = r_pc + 1'b1;   // wraps modulo 2^AW
  assign w_sp_dec = r_sp - 1'b1;

  // Next PC / stack pointer / sticky flags; ret > Call > JMP > PCpp > hold.
  always_comb begin
    w_pc_nxt  = r_pc;
    w_sp_nxt  = r_sp;
    w_ovf_nxt = r_ovf;
    w_unf_nxt = r_unf;
    w_push    = 1'b0;
    if (w_step) begin
      if (ret) begin
        if (r_sp != '0) begin
          w_pc_nxt = r_stack[w_sp_dec[IXW-1:0]];
          w_sp_nxt = w_sp_dec;
        end else begin
          w_pc_nxt  = RESET_VEC;
          w_unf_nxt = 1'b1;
        end
      end else if (Call) begin
        // A full stack drops the return address but still takes the jump.
        if (r_sp != SP_FULL) begin
          w_push   = 1'b1;
          w_sp_nxt = r_sp + 1'b1;
        end else begin
          w_ovf_nxt = 1'b1;
        end
        w_pc_nxt = JADDR;
      end else if (JMP) begin
        w_pc_nxt = JADDR;
      end else if (PCpp) begin
        w_pc_nxt = w_pc_inc;
      end
    end
  end

  // Architectural registers; reset abandons any in-flight fetch.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_pc  <= RESET_VEC;
      r_ir  <= '0;
      r_sp  <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_pc  <= w_pc_nxt;
      r_sp  <= w_sp_nxt;
      r_ovf <= w_ovf_nxt;
      r_unf <= w_unf_nxt;
      if (w_load_ir) r_ir <= IMEM_DATA;
    end
  end

  // Return stack storage; contents need no reset since SP gates every read.
  always_ff @(posedge CLK) begin
    if (w_push) r_stack[r_sp[IXW-1:0]] <= w_pc_inc;
  end

  assign IMEM_ADDR = r_pc;
  assign IR        = r_ir;
  assign OPCode    = r_ir[IW-1:IW-5];
  assign A         = r_ir[IW-6:IW-7];
  assign EXEC      = w_exec;
  assign SP        = r_sp;
  assign OVF       = r_ovf;
  assign UNF       = r_unf;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a queue-based reference model checked every
// cycle, plus directed sequences with literal expectations.
module tb_fetch_sequencer;
  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        STALL, PCpp, JMP, ret, Call;
  logic [15:0] JADDR, IMEM_ADDR, IMEM_DATA, IR;
  logic [4:0]  OPCode;
  logic [1:0]  A;
  logic        EXEC, OVF, UNF;
  logic [3:0]  SP;

  int checks = 0;
  int errors = 0;

  fetch_sequencer #(.AW(16), .IW(16), .DEPTH(8), .RESET_VEC(16'h0000)) dut (
    .CLK(CLK), .RSTn(RSTn), .STALL(STALL),
    .IMEM_ADDR(IMEM_ADDR), .IMEM_DATA(IMEM_DATA),
    .IR(IR), .OPCode(OPCode), .A(A), .EXEC(EXEC),
    .PCpp(PCpp), .JMP(JMP), .ret(ret), .Call(Call), .JADDR(JADDR),
    .SP(SP), .OVF(OVF), .UNF(UNF)
  );

  always #5 CLK = ~CLK;

  // Program ROM contents: a fixed hash of the address.
  function automatic logic [15:0] rom_f(input logic [15:0] a);
    logic [15:0] p;
    p = a * 16'h9E37;
    return p ^ 16'h5A5A;
  endfunction

  assign IMEM_DATA = rom_f(IMEM_ADDR);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase bit, PC, IR, stack as a queue.
  logic [15:0] m_pc = 16'h0000;
  logic [15:0] m_ir = 16'h0000;
  bit          m_exec = 1'b0;
  bit          m_ovf = 1'b0;
  bit          m_unf = 1'b0;
  logic [15:0] m_stk [$];

  initial begin
    forever begin
      @(posedge CLK or negedge RSTn);
      if (!RSTn) begin
        m_pc = 16'h0000; m_ir = 16'h0000; m_exec = 1'b0;
        m_ovf = 1'b0; m_unf = 1'b0; m_stk.delete();
      end else if (!STALL) begin
        if (!m_exec) begin
          m_ir   = rom_f(m_pc);
          m_exec = 1'b1;
        end else begin
          m_exec = 1'b0;
          if (ret) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin m_pc = 16'h0000; m_unf = 1'b1; end
          end else if (Call) begin
            if (m_stk.size() < 8) m_stk.push_back(m_pc + 16'd1);
            else m_ovf = 1'b1;
            m_pc = JADDR;
          end else if (JMP) m_pc = JADDR;
          else if (PCpp) m_pc = m_pc + 16'd1;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge CLK) begin
    chk("m_addr", 32'(IMEM_ADDR), 32'(m_pc));
    chk("m_exec", 32'(EXEC), 32'(m_exec));
    chk("m_ir",   32'(IR), 32'(m_ir));
    chk("m_opc",  32'(OPCode), 32'(m_ir[15:11]));
    chk("m_a",    32'(A), 32'(m_ir[10:9]));
    chk("m_sp",   32'(SP), 32'(m_stk.size()));
    chk("m_ovf",  32'(OVF), 32'(m_ovf));
    chk("m_unf",  32'(UNF), 32'(m_unf));
  end

  // Run one EXEC cycle with the given strobes. FETCH cycles see all strobes
  // high and a junk target, which the design must ignore.
  task automatic op(input logic pp, input logic j, input logic r, input logic c,
                    input logic [15:0] ja);
    int n = 0;
    while (!m_exec) begin
      {PCpp, JMP, ret, Call} = 4'hF; JADDR = 16'hDEAD;
      @(posedge CLK); #1;
      n++;
      if (n > 4) begin
        checks++; errors++;
        $display("FAIL op_wait: EXEC phase not reached within %0d cycles", n);
        break;
      end
    end
    PCpp = pp; JMP = j; ret = r; Call = c; JADDR = ja;
    @(posedge CLK); #1;
    {PCpp, JMP, ret, Call} = 4'hF; JADDR = 16'hDEAD;
  endtask

  logic [15:0] exp_addr [8] = '{16'h0, 16'h0, 16'h1, 16'h1, 16'h2, 16'h2, 16'h3, 16'h3};
  logic        exp_ex   [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    STALL = 1'b0; {PCpp, JMP, ret, Call} = 4'h0; JADDR = 16'h0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_addr", 32'(IMEM_ADDR), 32'h0);
    chk("rst_ir",   32'(IR), 32'h0);
    chk("rst_exec", 32'(EXEC), 32'h0);
    chk("rst_sp",   32'(SP), 32'h0);
    chk("rst_flags", 32'({OVF, UNF}), 32'h0);

    // Straight-line PCpp execution from reset.
    RSTn = 1'b1; PCpp = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      chk("seq_addr", 32'(IMEM_ADDR), 32'(exp_addr[i]));
      chk("seq_exec", 32'(EXEC), 32'(exp_ex[i]));
      if (i == 1) begin
        chk("seq_ir0", 32'(IR), 32'h5A5A);
        chk("seq_opc0", 32'(OPCode), 32'h0B);
        chk("seq_a0", 32'(A), 32'h1);
      end
      if (i == 3) chk("seq_ir1", 32'(IR), 32'hC46D);
    end

    // Plain jumps.
    op(0, 1, 0, 0, 16'h0010); chk("jmp1", 32'(IMEM_ADDR), 32'h0010);
    op(0, 1, 0, 0, 16'h0200); chk("jmp2", 32'(IMEM_ADDR), 32'h0200);
    chk("jmp_sp", 32'(SP), 32'h0);

    // Call / ret round trip.
    op(0, 1, 0, 0, 16'h0005);
    op(0, 0, 0, 1, 16'h0040); chk("call_addr", 32'(IMEM_ADDR), 32'h0040);
    chk("call_sp", 32'(SP), 32'h1);
    op(0, 1, 1, 0, 16'hBEEF); chk("ret_addr", 32'(IMEM_ADDR), 32'h0006);
    chk("ret_sp", 32'(SP), 32'h0);
    chk("ret_flags", 32'({OVF, UNF}), 32'h0);

    // Nine nested calls overflow an eight-deep stack.
    op(0, 1, 0, 0, 16'h0100);
    for (int k = 0; k < 9; k++) begin
      op(0, 0, 0, 1, 16'h0200 + 16'(k));
      chk("ovf_addr", 32'(IMEM_ADDR), 32'h0200 + 32'(k));
      chk("ovf_sp", 32'(SP), (k < 8) ? 32'(k + 1) : 32'd8);
      chk("ovf_flag", 32'(OVF), (k == 8) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 8; i++) begin
      op(0, 1, 1, 0, 16'hBEEF);
      chk("pop_addr", 32'(IMEM_ADDR), (i < 7) ? 32'h0207 - 32'(i) : 32'h0101);
      chk("pop_sp", 32'(SP), 32'(7 - i));
    end
    op(0, 1, 1, 0, 16'hBEEF);
    chk("unf_addr", 32'(IMEM_ADDR), 32'h0000);
    chk("unf_flag", 32'(UNF), 32'h1);
    chk("unf_sp", 32'(SP), 32'h0);

    // Address wrap on PCpp and on the pushed return address.
    op(0, 1, 0, 0, 16'hFFFF);
    op(1, 0, 0, 0, 16'h1234); chk("wrap_pp", 32'(IMEM_ADDR), 32'h0000);
    op(0, 1, 0, 0, 16'hFFFF);
    op(0, 0, 0, 1, 16'h0300);
    op(0, 1, 1, 0, 16'hBEEF); chk("wrap_call", 32'(IMEM_ADDR), 32'h0000);

    // Strobe priority.
    op(0, 1, 0, 0, 16'h0400);
    op(0, 0, 0, 1, 16'h0500);
    op(0, 1, 1, 1, 16'h0600); chk("ret_over_call", 32'(IMEM_ADDR), 32'h0401);
    chk("ret_over_call_sp", 32'(SP), 32'h0);
    op(0, 1, 0, 1, 16'h0700); chk("call_jmp", 32'(IMEM_ADDR), 32'h0700);
    chk("call_jmp_sp", 32'(SP), 32'h1);
    op(1, 1, 0, 0, 16'h0800); chk("jmp_over_pp", 32'(IMEM_ADDR), 32'h0800);
    op(0, 0, 0, 0, 16'h0900); chk("halt1", 32'(IMEM_ADDR), 32'h0800);
    op(0, 0, 0, 0, 16'h0900); chk("halt2", 32'(IMEM_ADDR), 32'h0800);
    op(0, 1, 1, 0, 16'hBEEF); chk("ret2", 32'(IMEM_ADDR), 32'h0402);

    // Stall during FETCH.
    STALL = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("fstall_exec", 32'(EXEC), 32'h0);
    chk("fstall_addr", 32'(IMEM_ADDR), 32'h0402);
    STALL = 1'b0;

    // Stall for three cycles during EXEC with a jump pending.
    op(0, 1, 0, 0, 16'h0050);
    {PCpp, JMP, ret, Call} = 4'h0;
    @(posedge CLK); #1;
    chk("estall_enter", 32'(EXEC), 32'h1);
    STALL = 1'b1; JMP = 1'b1; JADDR = 16'h0777;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      chk("estall_exec", 32'(EXEC), 32'h1);
      chk("estall_addr", 32'(IMEM_ADDR), 32'h0050);
      chk("estall_sp", 32'(SP), 32'h0);
    end
    STALL = 1'b0;
    @(posedge CLK); #1;
    {PCpp, JMP, ret, Call} = 4'h0;
    chk("estall_resume", 32'(IMEM_ADDR), 32'h0777);
    chk("estall_fetch", 32'(EXEC), 32'h0);

    // Asynchronous reset in the middle of a Call.
    op(0, 0, 0, 1, 16'h0030);
    {PCpp, JMP, ret, Call} = 4'h0;
    @(posedge CLK); #1;
    Call = 1'b1; JADDR = 16'h0999;
    #2 RSTn = 1'b0;
    #1;
    chk("arst_ir", 32'(IR), 32'h0);
    chk("arst_addr", 32'(IMEM_ADDR), 32'h0);
    chk("arst_sp", 32'(SP), 32'h0);
    chk("arst_exec", 32'(EXEC), 32'h0);
    chk("arst_flags", 32'({OVF, UNF}), 32'h0);
    @(posedge CLK); #1;
    RSTn = 1'b1; {PCpp, JMP, ret, Call} = 4'h0;
    @(negedge CLK);
    chk("post_rst_addr", 32'(IMEM_ADDR), 32'h0);
    chk("post_rst_exec", 32'(EXEC), 32'h0);
    @(negedge CLK);
    chk("post_rst_ir", 32'(IR), 32'h5A5A);
    chk("post_rst_sp", 32'(SP), 32'h0);

    repeat (2) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
